// File: rtl/beep_sequencer.sv
// Tune player for the game buzzer. Selects a START or OVER melody from gamemode,
// steps through a half-period ROM, and produces a square wave on beep.
module beep_sequencer #(
    parameter int DIV_W      = 18,
    parameter int NOTES      = 16,
    parameter int NOTE_TICKS = 12_500_000,
    parameter int GAP_TICKS  = 1_250_000,
    parameter int REPEAT     = 0,
    parameter int TEST_TUNE  = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [1:0]               gamemode,
    input  logic                     mute,
    output logic                     beep,
    output logic                     busy,
    output logic [$clog2(NOTES)-1:0] note_idx
);

    // state | meaning
    // IDLE  | silent, waiting for a tune trigger
    // PLAY  | sounding the current note for NOTE_TICKS clocks
    // GAP   | silent pause of GAP_TICKS clocks between notes
    // DONE  | tune finished; waits for a trigger or a 01/10 mode
    typedef enum logic [1:0] {S_IDLE, S_PLAY, S_GAP, S_DONE} state_t;

    localparam int IW   = $clog2(NOTES);
    localparam int DW_N = $clog2(NOTE_TICKS);
    localparam int DW_G = $clog2(GAP_TICKS);
    localparam int DW_M = (DW_N > DW_G) ? DW_N : DW_G;
    localparam int DW   = (DW_M < 1) ? 1 : DW_M;
    localparam logic [DIV_W-1:0] END_MARK = '1;

    state_t           state, state_n;
    logic [1:0]       prev_mode;
    logic             tune_sel, tune_sel_n;
    logic [IW-1:0]    idx_n;
    logic [DIV_W-1:0] tone_cnt, tone_cnt_n;
    logic [DW-1:0]    dur_cnt, dur_cnt_n;
    logic             phase, phase_n;
    logic             beep_n;
    logic [DIV_W-1:0] cur_half, next_half, start_half;
    logic [IW-1:0]    nxt_idx;
    logic             mode_chg, trig;

    // Half-period table; 0 is a rest, all-ones ends the tune.
    function automatic logic [DIV_W-1:0] rom_entry(input logic sel, input logic [IW-1:0] idx);
        logic [DIV_W-1:0] v;
        int               i;
        v = END_MARK;
        i = int'(idx);
        if (TEST_TUNE != 0) begin
            if (!sel) begin
                case (i)
                    0:       v = DIV_W'(3);
                    1:       v = DIV_W'(0);
                    2:       v = DIV_W'(5);
                    default: v = END_MARK;
                endcase
            end else begin
                case (i)
                    0:       v = DIV_W'(2);
                    default: v = END_MARK;
                endcase
            end
        end else begin
            if (!sel) begin
                case (i)
                    0:       v = DIV_W'(95602);
                    1:       v = DIV_W'(75838);
                    2:       v = DIV_W'(63776);
                    3:       v = DIV_W'(47801);
                    default: v = END_MARK;
                endcase
            end else begin
                case (i)
                    0:       v = DIV_W'(63776);
                    1:       v = DIV_W'(75838);
                    2:       v = DIV_W'(95602);
                    3:       v = DIV_W'(127551);
                    default: v = END_MARK;
                endcase
            end
        end
        return v;
    endfunction

    // State, counters, mode history and the registered buzzer output.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            prev_mode <= 2'b01;
            tune_sel  <= 1'b0;
            note_idx  <= '0;
            tone_cnt  <= '0;
            dur_cnt   <= '0;
            phase     <= 1'b0;
            beep      <= 1'b0;
        end else begin
            state     <= state_n;
            prev_mode <= gamemode;
            tune_sel  <= tune_sel_n;
            note_idx  <= idx_n;
            tone_cnt  <= tone_cnt_n;
            dur_cnt   <= dur_cnt_n;
            phase     <= phase_n;
            beep      <= beep_n;
        end
    end

    // Next-state logic: mode changes override note and gap expiry.
    always_comb begin
        state_n    = state;
        tune_sel_n = tune_sel;
        idx_n      = note_idx;
        tone_cnt_n = tone_cnt;
        dur_cnt_n  = dur_cnt;
        phase_n    = phase;

        cur_half   = rom_entry(tune_sel, note_idx);
        nxt_idx    = note_idx + 1'b1;
        next_half  = rom_entry(tune_sel, nxt_idx);
        start_half = rom_entry(gamemode == 2'b11, '0);
        mode_chg   = (gamemode != prev_mode);
        trig       = mode_chg && ((gamemode == 2'b00) || (gamemode == 2'b11));

        if (trig) begin
            tune_sel_n = (gamemode == 2'b11);
            idx_n      = '0;
            tone_cnt_n = '0;
            dur_cnt_n  = '0;
            phase_n    = 1'b0;
            state_n    = (start_half == END_MARK) ? S_DONE : S_PLAY;
        end else if (mode_chg) begin
            state_n    = S_IDLE;
            idx_n      = '0;
            tone_cnt_n = '0;
            dur_cnt_n  = '0;
            phase_n    = 1'b0;
        end else begin
            case (state)
                S_PLAY: begin
                    if (dur_cnt == DW'(NOTE_TICKS - 1)) begin
                        state_n    = S_GAP;
                        dur_cnt_n  = '0;
                        tone_cnt_n = '0;
                        phase_n    = 1'b0;
                    end else begin
                        dur_cnt_n = dur_cnt + 1'b1;
                        if (cur_half == '0) begin
                            tone_cnt_n = '0;
                            phase_n    = 1'b0;
                        end else if (tone_cnt == cur_half - 1'b1) begin
                            tone_cnt_n = '0;
                            phase_n    = ~phase;
                        end else begin
                            tone_cnt_n = tone_cnt + 1'b1;
                        end
                    end
                end
                S_GAP: begin
                    if (dur_cnt == DW'(GAP_TICKS - 1)) begin
                        dur_cnt_n  = '0;
                        tone_cnt_n = '0;
                        phase_n    = 1'b0;
                        if ((note_idx == IW'(NOTES - 1)) || (next_half == END_MARK)) begin
                            if (REPEAT != 0) begin
                                state_n = S_PLAY;
                                idx_n   = '0;
                            end else begin
                                state_n = S_DONE;
                            end
                        end else begin
                            state_n = S_PLAY;
                            idx_n   = nxt_idx;
                        end
                    end else begin
                        dur_cnt_n = dur_cnt + 1'b1;
                    end
                end
                default: begin
                    state_n = state;
                end
            endcase
        end

        beep_n = phase_n & ~mute;
    end

    assign busy = (state == S_PLAY) || (state == S_GAP);

endmodule

// File: tb/tb_beep_sequencer.sv
// Directed bench: u0 plays tunes once, u1 loops them. Short test tunes and note timing.
module tb_beep_sequencer;

    logic       clk;
    logic       rst0, rst1;
    logic [1:0] gm0, gm1;
    logic       mute0, mute1;
    logic       beep0, beep1, busy0, busy1;
    logic [3:0] idx0, idx1;

    int checks = 0;
    int errors = 0;

    beep_sequencer #(.DIV_W(18), .NOTES(16), .NOTE_TICKS(12), .GAP_TICKS(4),
                     .REPEAT(0), .TEST_TUNE(1)) u0 (
        .clk(clk), .rst(rst0), .gamemode(gm0), .mute(mute0),
        .beep(beep0), .busy(busy0), .note_idx(idx0));

    beep_sequencer #(.DIV_W(18), .NOTES(16), .NOTE_TICKS(12), .GAP_TICKS(4),
                     .REPEAT(1), .TEST_TUNE(1)) u1 (
        .clk(clk), .rst(rst1), .gamemode(gm1), .mute(mute1),
        .beep(beep1), .busy(busy1), .note_idx(idx1));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Records beep of the chosen instance for n cycles (bit i = cycle i).
    task automatic capture(input int dut, input int n, output logic [31:0] bits, output logic all_busy);
        bits = '0;
        all_busy = 1'b1;
        for (int i = 0; i < n; i++) begin
            bits[i]  = (dut == 1) ? beep1 : beep0;
            all_busy = all_busy & ((dut == 1) ? busy1 : busy0);
            tick();
        end
    endtask

    task automatic test_reset();
        rst0 = 1'b1; rst1 = 1'b1; gm0 = 2'b00; gm1 = 2'b01; mute0 = 1'b0; mute1 = 1'b0;
        tick(); tick();
        checks++; if (busy0 !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy0); end
        checks++; if (beep0 !== 1'b0) begin errors++; $display("FAIL reset_beep: got %b expected 0", beep0); end
        checks++; if (idx0 !== 4'd0) begin errors++; $display("FAIL reset_idx: got %0d expected 0", idx0); end
        checks++; if (busy1 !== 1'b0) begin errors++; $display("FAIL reset_busy_u1: got %b expected 0", busy1); end
    endtask

    task automatic test_start_tune();
        logic [31:0] b;
        logic        ab;
        rst0 = 1'b0;
        tick();
        checks++; if (busy0 !== 1'b1) begin errors++; $display("FAIL start_busy: got %b expected 1", busy0); end
        checks++; if (idx0 !== 4'd0) begin errors++; $display("FAIL start_idx0: got %0d expected 0", idx0); end
        capture(0, 12, b, ab);
        checks++; if (b[11:0] !== 12'hE38) begin errors++; $display("FAIL note0_wave: got %h expected e38", b[11:0]); end
        checks++; if (busy0 !== 1'b1) begin errors++; $display("FAIL gap0_busy: got %b expected 1", busy0); end
        capture(0, 4, b, ab);
        checks++; if (b[3:0] !== 4'h0) begin errors++; $display("FAIL gap0_wave: got %h expected 0", b[3:0]); end
        checks++; if (idx0 !== 4'd1) begin errors++; $display("FAIL note1_idx: got %0d expected 1", idx0); end
        capture(0, 16, b, ab);
        checks++; if (b[15:0] !== 16'h0000) begin errors++; $display("FAIL rest_wave: got %h expected 0000", b[15:0]); end
        checks++; if (ab !== 1'b1) begin errors++; $display("FAIL rest_busy: got %b expected 1", ab); end
        checks++; if (idx0 !== 4'd2) begin errors++; $display("FAIL note2_idx: got %0d expected 2", idx0); end
        capture(0, 12, b, ab);
        checks++; if (b[11:0] !== 12'h3E0) begin errors++; $display("FAIL note2_wave: got %h expected 3e0", b[11:0]); end
        capture(0, 4, b, ab);
        checks++; if (busy0 !== 1'b0) begin errors++; $display("FAIL done_busy: got %b expected 0", busy0); end
        checks++; if (beep0 !== 1'b0) begin errors++; $display("FAIL done_beep: got %b expected 0", beep0); end
    endtask

    task automatic test_done_hold();
        logic any_beep, any_busy;
        logic [31:0] b;
        logic        ab;
        any_beep = 1'b0; any_busy = 1'b0;
        for (int i = 0; i < 100; i++) begin
            any_beep = any_beep | beep0;
            any_busy = any_busy | busy0;
            tick();
        end
        checks++; if (any_busy !== 1'b0) begin errors++; $display("FAIL hold_retrigger: got %b expected 0", any_busy); end
        checks++; if (any_beep !== 1'b0) begin errors++; $display("FAIL hold_beep: got %b expected 0", any_beep); end
        gm0 = 2'b11;
        tick();
        checks++; if (busy0 !== 1'b1) begin errors++; $display("FAIL over_busy: got %b expected 1", busy0); end
        capture(0, 12, b, ab);
        checks++; if (b[11:0] !== 12'hCCC) begin errors++; $display("FAIL over_wave: got %h expected ccc", b[11:0]); end
        capture(0, 4, b, ab);
        checks++; if (busy0 !== 1'b0) begin errors++; $display("FAIL over_done: got %b expected 0", busy0); end
    endtask

    task automatic test_mode_change();
        logic [31:0] b;
        logic        ab;
        gm0 = 2'b00;
        tick();
        for (int i = 0; i < 4; i++) tick();
        checks++; if (beep0 !== 1'b1) begin errors++; $display("FAIL mid_note_beep: got %b expected 1", beep0); end
        gm0 = 2'b01;
        tick();
        checks++; if (busy0 !== 1'b0) begin errors++; $display("FAIL chg_busy: got %b expected 0", busy0); end
        checks++; if (beep0 !== 1'b0) begin errors++; $display("FAIL chg_beep: got %b expected 0", beep0); end
        checks++; if (idx0 !== 4'd0) begin errors++; $display("FAIL chg_idx: got %0d expected 0", idx0); end
        gm0 = 2'b00;
        tick();
        checks++; if (busy0 !== 1'b1) begin errors++; $display("FAIL restart_busy: got %b expected 1", busy0); end
        capture(0, 12, b, ab);
        checks++; if (b[11:0] !== 12'hE38) begin errors++; $display("FAIL restart_wave: got %h expected e38", b[11:0]); end
    endtask

    task automatic test_reset_mid_gap();
        logic [31:0] b;
        logic        ab;
        capture(0, 4, b, ab);
        checks++; if (idx0 !== 4'd1) begin errors++; $display("FAIL pre_rst_idx: got %0d expected 1", idx0); end
        for (int i = 0; i < 13; i++) tick();
        checks++; if (busy0 !== 1'b1) begin errors++; $display("FAIL pre_rst_busy: got %b expected 1", busy0); end
        rst0 = 1'b1;
        tick();
        checks++; if (busy0 !== 1'b0) begin errors++; $display("FAIL rst_gap_busy: got %b expected 0", busy0); end
        checks++; if (beep0 !== 1'b0) begin errors++; $display("FAIL rst_gap_beep: got %b expected 0", beep0); end
        checks++; if (idx0 !== 4'd0) begin errors++; $display("FAIL rst_gap_idx: got %0d expected 0", idx0); end
        tick();
        rst0 = 1'b0;
        tick();
        checks++; if (busy0 !== 1'b1) begin errors++; $display("FAIL rst_retrigger: got %b expected 1", busy0); end
    endtask

    task automatic test_mute();
        logic [31:0] b;
        logic        ab;
        b = '0;
        for (int i = 0; i < 12; i++) begin
            b[i]  = beep0;
            mute0 = (i >= 2) && (i <= 6);
            tick();
        end
        checks++; if (b[11:0] !== 12'hE00) begin errors++; $display("FAIL mute_wave: got %h expected e00", b[11:0]); end
        checks++; if (idx0 !== 4'd0) begin errors++; $display("FAIL mute_gap_idx: got %0d expected 0", idx0); end
        capture(0, 4, b, ab);
        checks++; if (idx0 !== 4'd1) begin errors++; $display("FAIL mute_next_idx: got %0d expected 1", idx0); end
    endtask

    task automatic test_repeat();
        logic [31:0] b;
        logic        ab;
        rst1 = 1'b0;
        tick();
        checks++; if (busy1 !== 1'b0) begin errors++; $display("FAIL rep_no_trig: got %b expected 0", busy1); end
        gm1 = 2'b10;
        tick();
        checks++; if (busy1 !== 1'b0) begin errors++; $display("FAIL rep_silent10: got %b expected 0", busy1); end
        gm1 = 2'b11;
        tick();
        for (int r = 0; r < 3; r++) begin
            checks++; if (idx1 !== 4'd0) begin errors++; $display("FAIL rep_idx pass %0d: got %0d expected 0", r, idx1); end
            capture(1, 16, b, ab);
            checks++; if (b[15:0] !== 16'h0CCC) begin errors++; $display("FAIL rep_wave pass %0d: got %h expected 0ccc", r, b[15:0]); end
            checks++; if (ab !== 1'b1) begin errors++; $display("FAIL rep_busy pass %0d: got %b expected 1", r, ab); end
        end
    endtask

    initial begin
        test_reset();
        test_start_tune();
        test_done_hold();
        test_mode_change();
        test_reset_mid_gap();
        test_mute();
        test_repeat();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not reach the summary");
        $fatal(1, "timeout");
    end

endmodule
